// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        CONF      = 3'd0,
        IDLE      = 3'd1,
        SEND      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } txarb_state_t;

    localparam int BYTE_W           = 8;
    localparam int DEF_BUSY_TIMEOUT = 1024;

endpackage

// File: rtl/rr_pointer_pick.sv
// Round-robin pointer register plus wrap-around first-set search above the pointer.
module rr_pointer_pick #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     en,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] ptr;
    int               j;

    // Scan from farthest to nearest so the nearest set bit above ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                idx   = IDX_W'(j);
                valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDX_W'(N_REQ - 1);
        end else if (en) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers.
// Optional busy-handshake timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*BYTE_W-1:0] Data,
    output logic [N_REQ-1:0]        Gnt,
    output logic [N_REQ-1:0]        Done,
    output logic                    Err,
    output logic                    Send,
    output logic                    Conf,
    output logic [BYTE_W-1:0]       DPin,
    input  logic                    Busy,
    output logic                    Active
);

    localparam int IDX_W = $clog2(N_REQ);

    txarb_state_t     state, state_nxt;
    logic [IDX_W-1:0] pick_idx, idx_q;
    logic             pick_vld, grant_en, timeout;
    logic [N_REQ-1:0] gnt_nxt, done_nxt;
    logic             send_nxt, conf_nxt, active_nxt;

    // Foreign traffic on the line blocks a new grant.
    assign grant_en = (state == IDLE) && pick_vld && !Busy;

    rr_pointer_pick #(.N_REQ(N_REQ)) u_pick (
        .clk   (Clk),
        .rst_n (Rst),
        .req   (Req),
        .en    (grant_en),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= CONF;
            DPin   <= '0;
            idx_q  <= '0;
            Gnt    <= '0;
            Done   <= '0;
            Send   <= 1'b0;
            Conf   <= 1'b0;
            Active <= 1'b0;
        end else begin
            state  <= state_nxt;
            Gnt    <= gnt_nxt;
            Done   <= done_nxt;
            Send   <= send_nxt;
            Conf   <= conf_nxt;
            Active <= active_nxt;
            if (grant_en) begin
                DPin  <= Data[pick_idx*BYTE_W +: BYTE_W];
                idx_q <= pick_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONF:      state_nxt = IDLE;
            IDLE:      if (grant_en) state_nxt = SEND;
            SEND:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (Busy)         state_nxt = WAIT_DONE;
                else if (timeout) state_nxt = IDLE;
            end
            WAIT_DONE: if (!Busy) state_nxt = IDLE;
            default:   state_nxt = CONF;
        endcase
    end

    // Outputs are registered, so they are derived from the transition being taken.
    always_comb begin
        gnt_nxt    = '0;
        done_nxt   = '0;
        send_nxt   = (state_nxt == SEND);
        conf_nxt   = (state == CONF);
        active_nxt = (state_nxt != IDLE);
        if (state == WAIT_BUSY && Busy)  gnt_nxt  = N_REQ'(1) << idx_q;
        if (state == WAIT_DONE && !Busy) done_nxt = N_REQ'(1) << idx_q;
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst || state != WAIT_BUSY) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == WAIT_BUSY) && !Busy && (wait_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Err <= 1'b0;
        end else begin
            Err <= timeout;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^BUSY_TIMEOUT;
    assign timeout        = 1'b0;
    assign Err            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: round-robin reference model, transmitter model, requester drivers.
module tb_uart_tx_arbiter;

    localparam int N_REQ      = 4;
    localparam int TB_TIMEOUT = 16;

    logic                 Clk, Rst;
    logic [N_REQ-1:0]     Req;
    logic [N_REQ*8-1:0]   Data;
    logic [N_REQ-1:0]     Gnt, Done;
    logic                 Err, Send, Conf, Active, Busy;
    logic [7:0]           DPin;

    uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Data(Data), .Gnt(Gnt), .Done(Done),
        .Err(Err), .Send(Send), .Conf(Conf), .DPin(DPin), .Busy(Busy), .Active(Active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_send[$];
    int         q_gnt[$];
    int         q_done[$];
    int         exp_err = 0;

    int         mptr = N_REQ - 1;
    logic [7:0] bytes[N_REQ][8];
    int         rem[N_REQ];
    int         nxt[N_REQ];
    int         dly[N_REQ];

    int         frame_len = 0;
    int         cur_len = 0;
    bit         tx_no_busy = 1'b0;
    int         cyc = 0;
    int         last_send = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter model: Busy rises two cycles after Send and stays high for the frame.
    initial begin
        Busy = 1'b0;
        forever begin
            @(posedge Clk); #1;
            if (Send === 1'b1 && !tx_no_busy) begin
                cur_len = (frame_len > 0) ? frame_len : int'($urandom_range(4, 12));
                @(posedge Clk);
                @(posedge Clk); #1;
                Busy = 1'b1;
                repeat (cur_len) @(posedge Clk);
                #1;
                Busy = 1'b0;
            end
        end
    end

    // Requesters: drop Req on Gnt, re-raise after a short random gap while bytes remain.
    initial begin
        Req  = '0;
        Data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0; nxt[i] = 0; dly[i] = 0;
        end
        forever begin
            @(posedge Clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (Gnt[i] === 1'b1) begin
                    Req[i] = 1'b0;
                    nxt[i]++;
                    rem[i]--;
                    dly[i] = int'($urandom_range(1, 3));
                end else if (!Req[i] && rem[i] > 0) begin
                    if (dly[i] > 0) dly[i]--;
                    else begin
                        Data[i*8 +: 8] = bytes[i][nxt[i]];
                        Req[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        int n;
        int g;
        forever begin
            @(posedge Clk); #1;
            cyc++;
            n = int'(Gnt != 0) + int'(Done != 0) + int'(Err === 1'b1);
            if (n > 0) chk("gnt_done_err_exclusive", n, 1);
            if (Send === 1'b1) begin
                if (q_send.size() == 0) chk("send_unexpected", 1, 0);
                else chk("dpin_at_send", DPin, q_send.pop_front());
                chk("busy_low_at_send", Busy, 0);
                chk("active_at_send", Active, 1);
                last_send = cyc;
                last_byte = DPin;
            end
            if (Gnt !== '0 && Gnt !== 'x) begin
                if (q_gnt.size() == 0) chk("gnt_unexpected", Gnt, 0);
                else begin
                    g = q_gnt.pop_front();
                    chk("gnt_onehot", Gnt, 32'(1) << g);
                    chk("gnt_latency", cyc - last_send, 3);
                    chk("dpin_hold_gnt", DPin, last_byte);
                end
            end
            if (Done !== '0 && Done !== 'x) begin
                if (q_done.size() == 0) chk("done_unexpected", Done, 0);
                else begin
                    g = q_done.pop_front();
                    chk("done_onehot", Done, 32'(1) << g);
                    chk("done_latency", cyc - last_send, cur_len + 3);
                    chk("dpin_hold_done", DPin, last_byte);
                end
            end
            if (Err === 1'b1) begin
                if (exp_err == 0) chk("err_unexpected", 1, 0);
                else begin
                    chk("err_latency", cyc - last_send, TB_TIMEOUT + 1);
                    exp_err--;
                end
            end
        end
    end

    task automatic do_reset();
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("outputs_in_reset", {Gnt, Done, Err, Send, Conf, DPin, Active}, 0);
        mptr = N_REQ - 1;
        Rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            chk("conf_pulse", Conf, (k == 0) ? 1 : 0);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q_send.size() + q_gnt.size() + q_done.size()) != 0 && k < 4000) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("drain", q_send.size() + q_gnt.size() + q_done.size(), 0);
        @(posedge Clk); #1;
        chk("idle_inactive", Active, 0);
    endtask

    // Reference: every requester with bytes left is pending at each grant, so order is
    // pure round-robin over non-empty requesters starting after the last winner.
    task automatic run_batch(input logic [15:0] cnt, input int fix);
        int left[N_REQ];
        int used[N_REQ];
        int total;
        int j;
        total = 0;
        for (int i = 0; i < N_REQ; i++) begin
            left[i] = int'(cnt[i*4 +: 4]);
            used[i] = 0;
            total += left[i];
            for (int k = 0; k < left[i]; k++)
                bytes[i][k] = (fix >= 0) ? 8'(fix) : 8'($urandom);
        end
        while (total > 0) begin
            j = mptr;
            do j = (j + 1) % N_REQ; while (left[j] == 0);
            q_send.push_back(bytes[j][used[j]]);
            q_gnt.push_back(j);
            q_done.push_back(j);
            used[j]++;
            left[j]--;
            total--;
            mptr = j;
        end
        for (int i = 0; i < N_REQ; i++) begin
            nxt[i] = 0;
            dly[i] = 0;
            rem[i] = int'(cnt[i*4 +: 4]);
        end
        wait_drain();
    endtask

    initial begin
        int k;
        logic [15:0] c;
        Rst = 1'b0;
        do_reset();

        frame_len = 20;
        run_batch(16'h0001, 8'hA5);
        frame_len = 0;

        do_reset();
        run_batch(16'h1112, -1);

        run_batch(16'h0010, -1);
        run_batch(16'h1010, -1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_REQ; i++) c[i*4 +: 4] = 4'($urandom_range(0, 3));
            if (c == 16'h0) c = 16'h0100;
            run_batch(c, -1);
        end

        // Reset in the middle of a frame: the byte gets its Gnt but never a Done.
        frame_len = 20;
        bytes[2][0] = 8'h3C;
        q_send.push_back(8'h3C);
        q_gnt.push_back(2);
        mptr = 2;
        nxt[2] = 0; dly[2] = 0; rem[2] = 1;
        k = 0;
        while (q_gnt.size() != 0 && k < 200) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("abort_gnt_seen", q_gnt.size(), 0);
        do_reset();
        frame_len = 0;
        run_batch(16'h1100, -1);

`ifdef UART_TX_ARB_TIMEOUT_EN
        tx_no_busy = 1'b1;
        bytes[1][0] = 8'h5A;
        q_send.push_back(8'h5A);
        exp_err = 1;
        mptr = 1;
        nxt[1] = 0; dly[1] = 0; rem[1] = 1;
        k = 0;
        while (q_send.size() != 0 && k < 200) begin
            @(posedge Clk); #1;
            k++;
        end
        rem[1] = 0;
        Req[1] = 1'b0;
        k = 0;
        while (exp_err != 0 && k < 200) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("timeout_err_seen", exp_err, 0);
        tx_no_busy = 1'b0;
        run_batch(16'h0110, -1);
`endif

        repeat (5) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one UART transmitter among `N_REQ` byte producers. It sequences the transmitter's `Send`/`Busy` handshake and issues the one-time `Conf` pulse after reset. It tells each requester when its byte was accepted and when it finished on the line. It sits between client logic and the transmit side of a UART pair, and drives that transmitter's `Send`, `Conf` and `DPin` inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 1024: cycles allowed for `Busy` to rise after `Send`. Used only with the timeout feature.

Ports:
- `Clk` in 1: single system clock.
- `Rst` in 1: reset, synchronous, active-low.
- `Req` in `N_REQ`: per-requester request. Held high until `Gnt`.
- `Data` in `N_REQ*8`: byte for requester i at bits `[8i+7:8i]`.
- `Gnt` out `N_REQ`: one-hot, 1-cycle pulse when the UART accepts the granted byte.
- `Done` out `N_REQ`: one-hot, 1-cycle pulse when that byte's frame completes.
- `Err` out 1: 1-cycle pulse on handshake timeout.
- `Send` out 1: 1-cycle start pulse to the transmitter.
- `Conf` out 1: 1-cycle configuration pulse to the transmitter.
- `DPin` out 8: registered byte to the transmitter.
- `Busy` in 1: transmitter busy flag.
- `Active` out 1: high in every state except `IDLE`.

## Operation
- States: `CONF`, `IDLE`, `SEND`, `WAIT_BUSY`, `WAIT_DONE`.
- **Reset** (`Rst`=0 at a clock edge):
  - state ← `CONF`, `DPin` ← 0, round-robin pointer ← `N_REQ-1`.
  - All outputs 0.
- **CONF:** `Conf`=1 for exactly one cycle, then `IDLE`.
- **IDLE:**
  - `Req` is sampled only in this state.
  - If any bit is set, pick the first set index above the pointer, wrapping modulo `N_REQ`.
  - Latch `Data[idx]` into `DPin`, store the index, go to `SEND`.
  - The pointer updates to the index on grant.
- **SEND:** `Send`=1 for one cycle, then `WAIT_BUSY`.
- **WAIT_BUSY:** on `Busy`=1, pulse `Gnt[idx]` and go to `WAIT_DONE`.
- **WAIT_DONE:** on `Busy`=0, pulse `Done[idx]` and return to `IDLE`.
- `DPin` is held stable from `SEND` until the next `IDLE` grant.
- **Requester rules:**
  - A requester that drops `Req` after selection still gets its byte sent, and still receives `Gnt` and `Done`.
  - A requester must deassert `Req` in the cycle after `Gnt`. If `Req` is still high when `IDLE` is re-entered, it is treated as a new byte.
- `Busy` already high on entry to `IDLE` (foreign traffic): no grant until `Busy`=0.
- Reset asserted mid-frame: the state machine restarts in `CONF` and no `Done` is issued for the aborted byte.

## Timing
- Grant latency:
  - `Req` high in `IDLE` at cycle t → `Send` at t+1.
  - `Gnt` one cycle after `Busy` is first seen high.
- `Done` is pulsed in the cycle after `Busy` is seen low.
- `IDLE` lasts at least 1 cycle between frames. Back-to-back throughput is frame time + 3 cycles.
- All outputs are registered. `Gnt`, `Done` and `Err` are never high together.
- Fairness: with all `Req` high continuously, grant order is 0,1,…,`N_REQ-1`,0.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_BUSY`.
  - If `BUSY_TIMEOUT` cycles pass without `Busy`, pulse `Err` and return to `IDLE`.
  - No `Gnt` or `Done` is issued for that byte. The pointer still advances past it.
- Undefined: `WAIT_BUSY` waits indefinitely, `Err` is tied to 0, and no counter is built.

## Structure
- Package `uart_ctrl_pkg` holds:
  - state enum `txarb_state_t`;
  - `BYTE_W` = 8;
  - default `BUSY_TIMEOUT`.
- Sub-module `rr_pointer_pick` owns the pointer register and the wrap-around first-set search:
  - inputs: request vector and a grant-enable strobe;
  - outputs: index and a valid flag.

## Test plan
- Reset release → `Conf` high exactly 1 cycle, then idle. All outputs 0 during reset.
- `Req`=0001, `Data[0]`=8'hA5, model raises `Busy` 2 cycles after `Send` for 20 cycles → `DPin`=A5, `Send` 1 pulse, `Gnt[0]` then `Done[0]`.
- `Req`=1111 held continuously, with each requester dropping `Req` after its `Gnt` and re-raising it later → grant order 0,1,2,3,0. Each `Done` matches its requester.
- `Req`=1010 with pointer=1 → requester 3 served before requester 1.
- `Busy` never rises, macro defined, `BUSY_TIMEOUT`=16 → `Err` 17 cycles after `Send`. No `Gnt`/`Done`. Next `Req` is served.
- `Rst` low during `WAIT_DONE` → restart in `CONF`, no `Done` for the aborted byte, pointer reset to `N_REQ-1`.
